vanilla_decode_queue: RTL and testbench
=======================================

Name: vanilla_decode_queue

Overview:
- Registered, parametrised decode stage between fetch and issue in the vanilla core.
- Decodes each accepted instruction into a decode_s record, stores the record with instruction and PC in a depth_p-entry FIFO, and presents the head to issue under a valid/yumi handshake.
- Over the previous purely combinational decode, it adds:
  - buffering;
  - flush;
  - illegal-opcode flagging;
  - an FPU-decode mode parameter;
  - fence ordering: a fence at the head is held until the memory system is idle.

Parameters:
- depth_p, 4, queue entries; power of two, minimum 2.
- pc_width_p, 22, PC field width in bits.
- fpu_en_p, 0, 1 enables decode of LOAD_FP/STORE_FP/OP_FP/SYSTEM-CSR rf1 reads; 0 treats those opcodes as illegal.

Ports:
- clk_i  in  1  core clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- v_i  in  1  fetch offers an instruction.
- instr_i  in  32  instruction word (instruction_s).
- pc_i  in  pc_width_p  PC of instr_i.
- ready_o  out  1  queue can accept; enqueue occurs when v_i & ready_o.
- v_o  out  1  head valid and releasable.
- decode_o  out  decode_s  decoded head record.
- illegal_o  out  1  head opcode not recognised.
- instr_o  out  32  head instruction word.
- pc_o  out  pc_width_p  head PC.
- yumi_i  in  1  issue consumes head; legal only when v_o=1.
- flush_i  in  1  discard all entries.
- mem_busy_i  in  1  loads/stores are outstanding in the memory system.
- count_o  out  $clog2(depth_p+1)  occupancy.

Behaviour:
- Reset: asynchronous on reset_n_i low.
  - Read pointer, write pointer and count clear to 0.
  - v_o=0, ready_o=1, count_o=0, illegal_o=0.
  - decode_o, instr_o and pc_o read as 0 because the storage array is cleared.
  - Reset mid-operation discards all contents; there is no partial state.
- Decode:
  - Combinational on instr_i, registered into the entry at enqueue.
  - Field semantics are identical to the existing decode_s rules.
  - illegal is set for any opcode outside LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP, OP_IMM, AMO and MISC_MEM, plus the FP opcodes when fpu_en_p=0.
  - MISC_MEM is illegal unless it decodes as fence or fence.i.
- Latency: an instruction enqueued in cycle N is visible at the outputs in cycle N+1 at the earliest. There is no bypass path.
- ready_o = (count != depth_p). It is registered-state only; it does not depend combinationally on yumi_i.
  - When full, a same-cycle yumi_i does not admit the offered instruction.
- Head release:
  - v_o = (count != 0) & ~(head.is_fence_op & mem_busy_i).
  - fence.i is not gated.
  - Non-fence heads are never gated.
- Simultaneous enqueue and dequeue (count between 1 and depth_p-1): count is unchanged and both pointers advance.
- Pointers are $clog2(depth_p) bits and wrap modulo depth_p.
- Flush:
  - flush_i high in cycle N: pointers and count are 0 in cycle N+1.
  - Flush overrides any enqueue or yumi in the same cycle; the offered instruction is dropped.
  - v_o is forced 0 during the flush cycle, so issue never sees a head it cannot take.
- Protocol violations:
  - yumi_i with v_o=0 is a violation. An assertion fires; the queue state is unchanged.
  - count never exceeds depth_p or underflows; assertions cover both.
- illegal_o: head.illegal & (count != 0).
  - Illegal entries dequeue normally. Trapping belongs to issue.
- Unused storage is never presented: when v_o=0, outputs are don't-care but stable.

Decomposition:
- Shared package (vanilla definitions):
  - decode_s: existing record, extended with an is_illegal bit.
  - decode_queue_entry_s: decode_s, instr, pc.
  - Opcode, funct3 and funct7 constants for AMO swap, fence and LR, reused unchanged.
- Sub-module vanilla_decode_core:
  - Combinational, parameter fpu_en_p.
  - Input: instruction_s. Output: decode_s including is_illegal.
  - The queue instantiates one core and a depth_p-entry register array.

Test Plan:
1. Reset then enqueue addi x1,x0,1 (0x00100093, pc 0x10):
   - Cycle+1: v_o=1, op_writes_rf=1, op_reads_rf1=1, op_reads_rf2=0, illegal_o=0, pc_o=0x10.
2. Fill to depth 4, then hold yumi_i=0:
   - Inputs: lw 0x0000A103, sw 0x0020A223, lr.w.aq 0x1400A1AF, 0xFFFFFFFF.
   - ready_o=0 and count_o=4.
   - Then yumi every cycle: heads appear in order with the following flags.
     - lw: is_load_op.
     - sw: is_store_op and op_reads_rf2.
     - lr.w.aq: op_is_load_reservation=1 and op_is_lr_acq=1.
     - 0xFFFFFFFF: illegal_o=1.
3. fence (0x0FF0000F) at head with mem_busy_i=1 for 5 cycles:
   - v_o=0 throughout.
   - mem_busy_i drops: v_o=1 the same cycle, is_fence_op=1.
   - Repeat with fence.i (0x0000100F): v_o=1 despite busy.
4. Count=2 with v_i=1 and yumi_i=1 for 10 cycles:
   - count_o stays 2.
   - Pointers wrap past 3→0.
   - Output order matches input order.
5. Count=3 and flush_i=1 together with v_i=1:
   - Next cycle count_o=0, v_o=0, ready_o=1.
   - The offered instruction is never emitted.
6. fpu_en_p=0 build, enqueue flw (0x0000A007):
   - illegal_o=1, is_mem_op=0.
   - fpu_en_p=1 build, same word: illegal_o=0, is_load_op=1, op_reads_rf1=1.
   - Additionally, assert reset_n_i mid-stream with count=3: v_o falls immediately (asynchronously), count_o=0.

Source files
------------

// File: rtl/vanilla_decode_queue_pkg.sv
// Shared vanilla-core definitions for the decode queue: instruction layout,
// decode record, queue entry and opcode/funct constants.
package vanilla_decode_queue_pkg;

    localparam int pc_max_width_gp = 32;

    localparam logic [6:0] op_lui_c      = 7'b0110111;
    localparam logic [6:0] op_auipc_c    = 7'b0010111;
    localparam logic [6:0] op_jal_c      = 7'b1101111;
    localparam logic [6:0] op_jalr_c     = 7'b1100111;
    localparam logic [6:0] op_branch_c   = 7'b1100011;
    localparam logic [6:0] op_load_c     = 7'b0000011;
    localparam logic [6:0] op_store_c    = 7'b0100011;
    localparam logic [6:0] op_op_c       = 7'b0110011;
    localparam logic [6:0] op_op_imm_c   = 7'b0010011;
    localparam logic [6:0] op_amo_c      = 7'b0101111;
    localparam logic [6:0] op_misc_mem_c = 7'b0001111;
    localparam logic [6:0] op_load_fp_c  = 7'b0000111;
    localparam logic [6:0] op_store_fp_c = 7'b0100111;
    localparam logic [6:0] op_op_fp_c    = 7'b1010011;
    localparam logic [6:0] op_system_c   = 7'b1110011;

    localparam logic [2:0] funct3_fence_c   = 3'b000;
    localparam logic [2:0] funct3_fence_i_c = 3'b001;
    localparam logic [4:0] amo_swap_funct5_c = 5'b00001;
    localparam logic [4:0] amo_lr_funct5_c   = 5'b00010;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] op;
    } instruction_s;

    typedef struct packed {
        logic op_writes_rf;
        logic op_reads_rf1;
        logic op_reads_rf2;
        logic is_load_op;
        logic is_store_op;
        logic is_mem_op;
        logic is_branch_op;
        logic is_jal_op;
        logic is_jalr_op;
        logic is_amo_op;
        logic op_is_load_reservation;
        logic op_is_lr_acq;
        logic is_fence_op;
        logic is_fence_i_op;
        logic is_fp_op;
        logic is_illegal;
    } decode_s;

    typedef struct packed {
        decode_s                     decode;
        logic [31:0]                 instr;
        logic [pc_max_width_gp-1:0]  pc;
    } decode_queue_entry_s;

endpackage

// File: rtl/vanilla_decode_core.sv
// Combinational instruction decoder producing a decode_s record; FP and CSR
// opcodes decode only when fpu_en_p is set, otherwise they are flagged illegal.
module vanilla_decode_core
    import vanilla_decode_queue_pkg::*;
#(
    parameter int fpu_en_p = 0
) (
    input  instruction_s instr_i,
    output decode_s      decode_o
);

    logic [4:0] funct5_s;
    logic       unused_s;

    assign funct5_s = instr_i.funct7[6:2];
    assign unused_s = ^{instr_i.rd, instr_i.rs1, instr_i.rs2};

    // Opcode classification; illegal encodings leave every other field clear.
    always_comb begin
        decode_o = '0;
        case (instr_i.op)
            op_lui_c, op_auipc_c: decode_o.op_writes_rf = 1'b1;
            op_jal_c: begin
                decode_o.op_writes_rf = 1'b1;
                decode_o.is_jal_op    = 1'b1;
            end
            op_jalr_c: begin
                decode_o.op_writes_rf = 1'b1;
                decode_o.op_reads_rf1 = 1'b1;
                decode_o.is_jalr_op   = 1'b1;
            end
            op_branch_c: begin
                decode_o.op_reads_rf1 = 1'b1;
                decode_o.op_reads_rf2 = 1'b1;
                decode_o.is_branch_op = 1'b1;
            end
            op_load_c: begin
                decode_o.op_writes_rf = 1'b1;
                decode_o.op_reads_rf1 = 1'b1;
                decode_o.is_load_op   = 1'b1;
                decode_o.is_mem_op    = 1'b1;
            end
            op_store_c: begin
                decode_o.op_reads_rf1 = 1'b1;
                decode_o.op_reads_rf2 = 1'b1;
                decode_o.is_store_op  = 1'b1;
                decode_o.is_mem_op    = 1'b1;
            end
            op_op_c: begin
                decode_o.op_writes_rf = 1'b1;
                decode_o.op_reads_rf1 = 1'b1;
                decode_o.op_reads_rf2 = 1'b1;
            end
            op_op_imm_c: begin
                decode_o.op_writes_rf = 1'b1;
                decode_o.op_reads_rf1 = 1'b1;
            end
            op_amo_c: begin
                decode_o.op_writes_rf = 1'b1;
                decode_o.op_reads_rf1 = 1'b1;
                decode_o.is_mem_op    = 1'b1;
                // LR has no rs2 operand; aq sits in funct7[1].
                if (funct5_s == amo_lr_funct5_c) begin
                    decode_o.op_is_load_reservation = 1'b1;
                    decode_o.is_load_op             = 1'b1;
                    decode_o.op_is_lr_acq           = instr_i.funct7[1];
                end else begin
                    decode_o.op_reads_rf2 = 1'b1;
                    decode_o.is_amo_op    = (funct5_s == amo_swap_funct5_c);
                end
            end
            op_misc_mem_c: begin
                if (instr_i.funct3 == funct3_fence_c) begin
                    decode_o.is_fence_op = 1'b1;
                end else if (instr_i.funct3 == funct3_fence_i_c) begin
                    decode_o.is_fence_i_op = 1'b1;
                end else begin
                    decode_o.is_illegal = 1'b1;
                end
            end
            op_load_fp_c, op_store_fp_c: begin
                if (fpu_en_p != 0) begin
                    decode_o.op_reads_rf1 = 1'b1;
                    decode_o.is_load_op   = (instr_i.op == op_load_fp_c);
                    decode_o.is_store_op  = (instr_i.op == op_store_fp_c);
                    decode_o.is_mem_op    = 1'b1;
                    decode_o.is_fp_op     = 1'b1;
                end else begin
                    decode_o.is_illegal = 1'b1;
                end
            end
            op_op_fp_c: begin
                // Integer-side traffic only for moves, converts and compares.
                if (fpu_en_p != 0) begin
                    decode_o.is_fp_op     = 1'b1;
                    decode_o.op_reads_rf1 = instr_i.funct7 inside {7'b1111000, 7'b1101000};
                    decode_o.op_writes_rf = instr_i.funct7 inside {7'b1110000, 7'b1010000, 7'b1100000};
                end else begin
                    decode_o.is_illegal = 1'b1;
                end
            end
            op_system_c: begin
                if (fpu_en_p != 0) begin
                    decode_o.is_fp_op     = 1'b1;
                    decode_o.op_reads_rf1 = instr_i.funct3 inside {3'b001, 3'b010, 3'b011};
                    decode_o.op_writes_rf = (instr_i.funct3 != 3'b000);
                end else begin
                    decode_o.is_illegal = 1'b1;
                end
            end
            default: decode_o.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/vanilla_decode_queue_chk.sv
// Protocol checks for the decode queue handshake and occupancy bounds.
module vanilla_decode_queue_chk #(
    parameter int depth_p = 4,
    parameter int cnt_w_p = 3
) (
    input logic               clk_i,
    input logic               reset_n_i,
    input logic               v_i,
    input logic               yumi_i,
    input logic [cnt_w_p-1:0] count_i
);

    yumi_needs_valid_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        yumi_i |-> v_i);

    count_in_range_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        count_i <= cnt_w_p'(depth_p));

endmodule

// File: rtl/vanilla_decode_queue.sv
// Registered decode stage: decodes at enqueue, buffers depth_p entries, and
// releases the head under valid/yumi with fence ordering against memory.
module vanilla_decode_queue
    import vanilla_decode_queue_pkg::*;
#(
    parameter int depth_p    = 4,
    parameter int pc_width_p = 22,
    parameter int fpu_en_p   = 0
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         v_i,
    input  logic [31:0]                  instr_i,
    input  logic [pc_width_p-1:0]        pc_i,
    output logic                         ready_o,
    output logic                         v_o,
    output decode_s                      decode_o,
    output logic                         illegal_o,
    output logic [31:0]                  instr_o,
    output logic [pc_width_p-1:0]        pc_o,
    input  logic                         yumi_i,
    input  logic                         flush_i,
    input  logic                         mem_busy_i,
    output logic [$clog2(depth_p+1)-1:0] count_o
);

    localparam int ptr_w_lp = $clog2(depth_p);
    localparam int cnt_w_lp = $clog2(depth_p + 1);
    localparam logic [cnt_w_lp-1:0] full_count_lp = cnt_w_lp'(depth_p);

    decode_queue_entry_s   mem_r [depth_p];
    logic [ptr_w_lp-1:0]   rd_ptr_r, wr_ptr_r;
    logic [cnt_w_lp-1:0]   count_r;

    instruction_s          instr_s;
    decode_s               dec_s;
    decode_queue_entry_s   head_s, new_entry_s;
    logic                  not_empty_s, enq_s, deq_s, unused_s;

    assign instr_s = instr_i;

    vanilla_decode_core #(.fpu_en_p(fpu_en_p)) core (
        .instr_i  (instr_s),
        .decode_o (dec_s)
    );

    assign new_entry_s = '{decode: dec_s, instr: instr_i, pc: pc_max_width_gp'(pc_i)};
    assign head_s      = mem_r[rd_ptr_r];
    assign not_empty_s = (count_r != {cnt_w_lp{1'b0}});

    // A fence waits at the head until outstanding memory traffic drains.
    assign ready_o = (count_r != full_count_lp);
    assign v_o     = not_empty_s & ~(head_s.decode.is_fence_op & mem_busy_i) & ~flush_i;
    assign enq_s   = v_i & ready_o & ~flush_i;
    assign deq_s   = yumi_i & v_o;

    assign decode_o  = head_s.decode;
    assign illegal_o = head_s.decode.is_illegal & not_empty_s;
    assign instr_o   = head_s.instr;
    assign pc_o      = head_s.pc[pc_width_p-1:0];
    assign count_o   = count_r;
    assign unused_s  = ^head_s.pc;

    // Entry storage, cleared on reset so an empty queue presents zeros.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < depth_p; i++) begin
                mem_r[i] <= '0;
            end
        end else if (enq_s) begin
            mem_r[wr_ptr_r] <= new_entry_s;
        end
    end

    // Pointer and occupancy update; flush wins over any enqueue or dequeue.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + ptr_w_lp'(1);
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + ptr_w_lp'(1);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + cnt_w_lp'(1);
                2'b01:   count_r <= count_r - cnt_w_lp'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    vanilla_decode_queue_chk #(.depth_p(depth_p), .cnt_w_p(cnt_w_lp)) chk (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (v_o),
        .yumi_i    (yumi_i),
        .count_i   (count_r)
    );

endmodule

// File: tb/tb_vanilla_decode_queue.sv
// Self-checking bench for vanilla_decode_queue: decode table, handshake corner
// sequences and a randomized run against a queue-based reference model.
module tb_vanilla_decode_queue;
    import vanilla_decode_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int PCW   = 22;

    logic clk = 1'b0;
    logic reset_n, v_i, yumi, flush, mem_busy;
    logic [31:0] instr;
    logic [PCW-1:0] pc;

    logic rdy0, v0, ill0, rdy1, v1, ill1;
    decode_s dec0, dec1;
    logic [31:0] instr0, instr1;
    logic [PCW-1:0] pc0, pc1;
    logic [2:0] cnt0, cnt1;

    int n_cmp = 0;
    int n_fail = 0;
    int step = 0;

    always #5 clk = ~clk;

    vanilla_decode_queue #(.depth_p(DEPTH), .pc_width_p(PCW), .fpu_en_p(0)) dut0 (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .instr_i(instr), .pc_i(pc),
        .ready_o(rdy0), .v_o(v0), .decode_o(dec0), .illegal_o(ill0), .instr_o(instr0),
        .pc_o(pc0), .yumi_i(yumi), .flush_i(flush), .mem_busy_i(mem_busy), .count_o(cnt0));

    vanilla_decode_queue #(.depth_p(DEPTH), .pc_width_p(PCW), .fpu_en_p(1)) dut1 (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .instr_i(instr), .pc_i(pc),
        .ready_o(rdy1), .v_o(v1), .decode_o(dec1), .illegal_o(ill1), .instr_o(instr1),
        .pc_o(pc1), .yumi_i(yumi), .flush_i(flush), .mem_busy_i(mem_busy), .count_o(cnt1));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got 0x%0h, want 0x%0h", nm, step, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        step++;
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] instr; logic [PCW-1:0] pc; } ent_t;
    ent_t mq[$];

    function automatic decode_s ref_decode(input logic [31:0] i, input bit fpu);
        decode_s d = '0;
        logic [6:0] op = i[6:0];
        logic [2:0] f3 = i[14:12];
        logic [4:0] f5 = i[31:27];
        logic [6:0] f7 = i[31:25];
        bit fp_op = op inside {7'h07, 7'h27, 7'h53, 7'h73};
        bit lr    = (op == 7'h2F) && (f5 == 5'd2);
        bit legal = (op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h33, 7'h13, 7'h2F})
                    || (op == 7'h0F && f3 inside {3'd0, 3'd1}) || (fp_op && fpu);
        if (!legal) begin
            d.is_illegal = 1'b1;
            return d;
        end
        d.is_load_op   = (op == 7'h03) || (op == 7'h07) || lr;
        d.is_store_op  = (op == 7'h23) || (op == 7'h27);
        d.is_mem_op    = d.is_load_op || d.is_store_op || (op == 7'h2F);
        d.op_writes_rf = (op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h33, 7'h13, 7'h2F})
                         || (op == 7'h73 && f3 != 3'd0) || (op == 7'h53 && f7 inside {7'h70, 7'h50, 7'h60});
        d.op_reads_rf1 = (op inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h33, 7'h13, 7'h2F, 7'h07, 7'h27})
                         || (op == 7'h73 && f3 inside {3'd1, 3'd2, 3'd3}) || (op == 7'h53 && f7 inside {7'h78, 7'h68});
        d.op_reads_rf2 = (op inside {7'h63, 7'h23, 7'h33}) || (op == 7'h2F && !lr);
        d.is_branch_op = (op == 7'h63);
        d.is_jal_op    = (op == 7'h6F);
        d.is_jalr_op   = (op == 7'h67);
        d.is_amo_op    = (op == 7'h2F) && (f5 == 5'd1);
        d.op_is_load_reservation = lr;
        d.op_is_lr_acq  = lr && i[26];
        d.is_fence_op   = (op == 7'h0F) && (f3 == 3'd0);
        d.is_fence_i_op = (op == 7'h0F) && (f3 == 3'd1);
        d.is_fp_op      = fp_op;
        return d;
    endfunction

    function automatic bit model_v();
        if (flush || mq.size() == 0) return 1'b0;
        return !(ref_decode(mq[0].instr, 1'b0).is_fence_op && mem_busy);
    endfunction

    task automatic model_step();
        bit rdy = (mq.size() != DEPTH);
        bit v   = model_v();
        if (flush) begin
            mq.delete();
        end else begin
            if (yumi && v) void'(mq.pop_front());
            if (v_i && rdy) mq.push_back('{instr, pc});
        end
    endtask

    task automatic check_model();
        int n = mq.size();
        bit ev = model_v();
        chk("rnd_count0", cnt0, n);
        chk("rnd_count1", cnt1, n);
        chk("rnd_ready", rdy0, n != DEPTH);
        chk("rnd_v0", v0, ev);
        chk("rnd_v1", v1, ev);
        if (n != 0) begin
            chk("rnd_instr", instr0, mq[0].instr);
            chk("rnd_pc", pc0, mq[0].pc);
            chk("rnd_dec0", dec0, ref_decode(mq[0].instr, 1'b0));
            chk("rnd_ill0", ill0, ref_decode(mq[0].instr, 1'b0).is_illegal);
            chk("rnd_dec1", dec1, ref_decode(mq[0].instr, 1'b1));
            chk("rnd_ill1", ill1, ref_decode(mq[0].instr, 1'b1).is_illegal);
        end else begin
            chk("rnd_ill_empty", ill0, 1'b0);
        end
    endtask

    logic [6:0] ops [15] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h33,
                             7'h13, 7'h2F, 7'h0F, 7'h07, 7'h27, 7'h53, 7'h73};

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        if ($urandom_range(7) == 0) return r;
        return {r[31:7], ops[$urandom_range(14)]};
    endfunction

    // ---------------- decode table ----------------
    typedef struct {
        logic [31:0] instr; logic [PCW-1:0] pc;
        logic wr, rf1, rf2, ld, st, mem, lr, acq, fen, ill, ill1;
    } vec_t;
    vec_t vt[14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] s [12];
        vt[0]  = '{32'h00100093, 22'h10,  1,1,0,0,0,0,0,0,0,0,0};
        vt[1]  = '{32'h0000A103, 22'h14,  1,1,0,1,0,1,0,0,0,0,0};
        vt[2]  = '{32'h0020A223, 22'h18,  0,1,1,0,1,1,0,0,0,0,0};
        vt[3]  = '{32'h1400A1AF, 22'h1C,  1,1,0,1,0,1,1,1,0,0,0};
        vt[4]  = '{32'hFFFFFFFF, 22'h20,  0,0,0,0,0,0,0,0,0,1,1};
        vt[5]  = '{32'h0FF0000F, 22'h24,  0,0,0,0,0,0,0,0,1,0,0};
        vt[6]  = '{32'h0000100F, 22'h28,  0,0,0,0,0,0,0,0,0,0,0};
        vt[7]  = '{32'h0000A007, 22'h2C,  0,0,0,0,0,0,0,0,0,1,0};
        vt[8]  = '{32'h002081B3, 22'h30,  1,1,1,0,0,0,0,0,0,0,0};
        vt[9]  = '{32'h00208463, 22'h34,  0,1,1,0,0,0,0,0,0,0,0};
        vt[10] = '{32'h123450B7, 22'h38,  1,0,0,0,0,0,0,0,0,0,0};
        vt[11] = '{32'h0000200F, 22'h3C,  0,0,0,0,0,0,0,0,0,1,1};
        vt[12] = '{32'h0820A1AF, 22'h40,  1,1,1,0,0,1,0,0,0,0,0};
        vt[13] = '{32'h00000073, 22'h3FFFFF, 0,0,0,0,0,0,0,0,0,1,0};

        reset_n = 1'b0; v_i = 1'b0; yumi = 1'b0; flush = 1'b0; mem_busy = 1'b0;
        instr = '0; pc = '0;
        #2;
        chk("rst_v", v0, 1'b0);
        chk("rst_ready", rdy0, 1'b1);
        chk("rst_count", cnt0, 3'd0);
        chk("rst_illegal", ill0, 1'b0);
        chk("rst_instr", instr0, 32'h0);
        chk("rst_pc", pc0, 22'h0);
        chk("rst_decode", dec0, 16'h0);
        #10 reset_n = 1'b1;
        tick();

        // Table: one instruction at a time through an empty queue.
        for (int i = 0; i < 14; i++) begin
            v_i = 1'b1; instr = vt[i].instr; pc = vt[i].pc;
            #1 chk("tbl_no_bypass", v0, 1'b0);
            tick();
            v_i = 1'b0;
            #1;
            chk("tbl_v", v0, 1'b1);
            chk("tbl_count", cnt0, 3'd1);
            chk("tbl_pc", pc0, vt[i].pc);
            chk("tbl_instr", instr0, vt[i].instr);
            chk("tbl_wr", dec0.op_writes_rf, vt[i].wr);
            chk("tbl_rf1", dec0.op_reads_rf1, vt[i].rf1);
            chk("tbl_rf2", dec0.op_reads_rf2, vt[i].rf2);
            chk("tbl_ld", dec0.is_load_op, vt[i].ld);
            chk("tbl_st", dec0.is_store_op, vt[i].st);
            chk("tbl_mem", dec0.is_mem_op, vt[i].mem);
            chk("tbl_lr", dec0.op_is_load_reservation, vt[i].lr);
            chk("tbl_acq", dec0.op_is_lr_acq, vt[i].acq);
            chk("tbl_fence", dec0.is_fence_op, vt[i].fen);
            chk("tbl_ill0", ill0, vt[i].ill);
            chk("tbl_ill1", ill1, vt[i].ill1);
            yumi = 1'b1;
            tick();
            yumi = 1'b0;
            #1 chk("tbl_drained", cnt0, 3'd0);
        end

        // flw on the FPU-enabled build.
        v_i = 1'b1; instr = 32'h0000A007; pc = 22'h50;
        tick();
        v_i = 1'b0;
        #1;
        chk("flw_fpu_ill", ill1, 1'b0);
        chk("flw_fpu_load", dec1.is_load_op, 1'b1);
        chk("flw_fpu_rf1", dec1.op_reads_rf1, 1'b1);
        chk("flw_nofpu_mem", dec0.is_mem_op, 1'b0);
        yumi = 1'b1; tick(); yumi = 1'b0;

        // Fill to depth; a yumi while full must not admit the offered word.
        s[0] = 32'h0000A103; s[1] = 32'h0020A223; s[2] = 32'h1400A1AF; s[3] = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            v_i = 1'b1; instr = s[i]; pc = PCW'(i);
            tick();
        end
        v_i = 1'b0;
        #1;
        chk("full_ready", rdy0, 1'b0);
        chk("full_count", cnt0, 3'd4);
        v_i = 1'b1; instr = 32'h00000013; yumi = 1'b1;
        #1 chk("full_head_lw", dec0.is_load_op, 1'b1);
        tick();
        v_i = 1'b0;
        #1;
        chk("full_no_admit", cnt0, 3'd3);
        chk("head_sw_store", dec0.is_store_op, 1'b1);
        chk("head_sw_rf2", dec0.op_reads_rf2, 1'b1);
        tick();
        chk("head_lr", dec0.op_is_load_reservation, 1'b1);
        chk("head_lr_acq", dec0.op_is_lr_acq, 1'b1);
        tick();
        chk("head_illegal", ill0, 1'b1);
        tick();
        yumi = 1'b0;
        #1;
        chk("drain_count", cnt0, 3'd0);
        chk("drain_v", v0, 1'b0);

        // Fence held while memory is busy; fence.i is not.
        v_i = 1'b1; instr = 32'h0FF0000F;
        tick();
        v_i = 1'b0; mem_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("fence_held", v0, 1'b0);
            tick();
        end
        mem_busy = 1'b0;
        #1;
        chk("fence_release", v0, 1'b1);
        chk("fence_flag", dec0.is_fence_op, 1'b1);
        yumi = 1'b1; tick(); yumi = 1'b0;
        v_i = 1'b1; instr = 32'h0000100F;
        tick();
        v_i = 1'b0; mem_busy = 1'b1;
        #1 chk("fence_i_not_held", v0, 1'b1);
        yumi = 1'b1; tick(); yumi = 1'b0; mem_busy = 1'b0;

        // Steady enqueue+dequeue at count 2 wraps the pointers.
        for (int k = 0; k < 12; k++) s[k] = 32'h00000013 | (32'(k) << 20);
        for (int k = 0; k < 2; k++) begin
            v_i = 1'b1; instr = s[k]; tick();
        end
        for (int k = 0; k < 10; k++) begin
            v_i = 1'b1; instr = s[k + 2]; yumi = 1'b1;
            #1;
            chk("stream_head", instr0, s[k]);
            chk("stream_count", cnt0, 3'd2);
            tick();
        end
        v_i = 1'b0;
        #1 chk("stream_tail0", instr0, s[10]);
        tick();
        chk("stream_tail1", instr0, s[11]);
        tick();
        yumi = 1'b0;
        #1 chk("stream_empty", cnt0, 3'd0);

        // Flush at count 3 drops the offered instruction.
        for (int k = 0; k < 3; k++) begin
            v_i = 1'b1; instr = s[k]; tick();
        end
        instr = 32'hDEAD0033; flush = 1'b1;
        #1 chk("flush_v_forced", v0, 1'b0);
        tick();
        flush = 1'b0; v_i = 1'b0;
        #1;
        chk("flush_count", cnt0, 3'd0);
        chk("flush_v", v0, 1'b0);
        chk("flush_ready", rdy0, 1'b1);
        v_i = 1'b1; instr = 32'h00500093;
        tick();
        v_i = 1'b0;
        #1 chk("flush_dropped", instr0, 32'h00500093);
        yumi = 1'b1; tick(); yumi = 1'b0;

        // Asynchronous reset with entries present.
        for (int k = 0; k < 3; k++) begin
            v_i = 1'b1; instr = s[k]; tick();
        end
        v_i = 1'b0;
        #1 chk("pre_reset_count", cnt0, 3'd3);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_v", v0, 1'b0);
        chk("async_rst_count", cnt0, 3'd0);
        chk("async_rst_ready", rdy0, 1'b1);
        chk("async_rst_instr", instr0, 32'h0);
        #3 reset_n = 1'b1;
        tick();

        // Randomized traffic against the reference model.
        mq.delete();
        for (int c = 0; c < 600; c++) begin
            v_i      = ($urandom_range(3) != 0);
            instr    = rand_instr();
            pc       = PCW'($urandom);
            flush    = ($urandom_range(24) == 0);
            mem_busy = ($urandom_range(2) == 0);
            yumi     = model_v() && ($urandom_range(2) != 0);
            #1;
            check_model();
            model_step();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
